// File: rtl/idex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-word bit positions, ALUOp
// encodings, hazard FSM state encodings and the NOP control word.
package idex_stage_pkg;

  localparam int CTRL_W = 12;

  localparam int REGWRITE_BIT = 11;
  localparam int MEMREAD_BIT  = 10;
  localparam int MEMWRITE_BIT = 9;
  localparam int MEMTOREG_BIT = 8;
  localparam int ALUSRC_BIT   = 7;
  localparam int REGDST_MSB   = 6;
  localparam int REGDST_LSB   = 5;
  localparam int ALUOP_MSB    = 4;
  localparam int ALUOP_LSB    = 0;

  typedef enum logic [4:0] {
    ALUOP_ADD  = 5'd0,
    ALUOP_SUB  = 5'd1,
    ALUOP_AND  = 5'd2,
    ALUOP_OR   = 5'd3,
    ALUOP_XOR  = 5'd4,
    ALUOP_NOR  = 5'd5,
    ALUOP_SLT  = 5'd6,
    ALUOP_SLTU = 5'd7,
    ALUOP_SLL  = 5'd8,
    ALUOP_SRL  = 5'd9,
    ALUOP_SRA  = 5'd10,
    ALUOP_LUI  = 5'd11
  } aluop_e;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  function automatic logic ctrl_memread(input logic [CTRL_W-1:0] ctrl);
    return ctrl[MEMREAD_BIT];
  endfunction

endpackage

// File: rtl/idex_stage_if.sv
// ID -> ID/EX bundle: decoded fields coming from ID and the registered ID/EX
// fields handed on to EX. The ID side drives through master, the stage is slave.
interface idex_stage_if #(
    parameter int DW = 32
);
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [DW-1:0] id_rd1;
    logic [DW-1:0] id_rd2;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [4:0]    id_rd;
    logic          id_use_rt;
    logic [11:0]   id_ctrl;

    logic          idex_valid;
    logic [DW-1:0] idex_pc;
    logic [DW-1:0] idex_rd1;
    logic [DW-1:0] idex_rd2;
    logic [DW-1:0] idex_imm;
    logic [4:0]    idex_rs;
    logic [4:0]    idex_rt;
    logic [4:0]    idex_rd;
    logic [11:0]   idex_ctrl;

    modport master (
        output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_use_rt, id_ctrl,
        input  idex_valid, idex_pc, idex_rd1, idex_rd2, idex_imm, idex_rs, idex_rt, idex_rd,
               idex_ctrl
    );

    modport slave (
        input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_use_rt, id_ctrl,
        output idex_valid, idex_pc, idex_rd1, idex_rd2, idex_imm, idex_rs, idex_rt, idex_rd,
               idex_ctrl
    );
endinterface

// File: rtl/idex_stage_load_use_detect.sv
// Load-use hazard compare: a valid load in ID/EX whose destination rt feeds a
// source operand of the valid instruction currently in ID.
module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rt,
    output logic       haz
);
    logic src_match;

    assign src_match = (ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt));
    // $0 is never a real dependency, so a load targeting it cannot stall.
    assign haz = ex_valid && ex_memread && (ex_rt != 5'd0) && id_valid && src_match;
endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall FSM for the 5-stage MIPS pipe.
// Optional performance counters are built when IDEX_PERF_CNT_EN is defined.
module idex_stage
    import idex_stage_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int DW         = 32
) (
    input  logic        clk,
    input  logic        rst,
    idex_stage_if.slave bus,
    input  logic        flush,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    localparam logic [1:0] BCNT_INIT = 2'(LU_BUBBLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic              valid_q, valid_d;
    logic [DW-1:0]     pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              haz;
    logic              bubble;

    load_use_detect u_load_use_detect (
        .ex_valid   (valid_q),
        .ex_memread (ctrl_memread(ctrl_q)),
        .ex_rt      (rt_q),
        .id_valid   (bus.id_valid),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_use_rt  (bus.id_use_rt),
        .haz        (haz)
    );

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch; the defaults also express "hold".
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        bubble     = 1'b0;

        if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (flush) begin
            bubble  = 1'b1;
            state_d = IDLE;
            bcnt_d  = '0;
        end else if (state_q == STALL) begin
            // bcnt counts the bubbles still owed after the one loaded now.
            bubble     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if (bcnt_q <= 2'd1) begin
                state_d = IDLE;
                bcnt_d  = '0;
            end else begin
                bcnt_d = bcnt_q - 2'd1;
            end
        end else if (haz) begin
            bubble     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bcnt_d     = BCNT_INIT;
            state_d    = (BCNT_INIT == 2'd0) ? IDLE : STALL;
        end else begin
            valid_d = bus.id_valid;
            pc_d    = bus.id_pc;
            rd1_d   = bus.id_rd1;
            rd2_d   = bus.id_rd2;
            imm_d   = bus.id_imm;
            rs_d    = bus.id_rs;
            rt_d    = bus.id_rt;
            rd_d    = bus.id_rd;
            ctrl_d  = bus.id_valid ? bus.id_ctrl : NOP_CTRL;
        end

        if (bubble) begin
            valid_d = 1'b0;
            pc_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            ctrl_d  = NOP_CTRL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= NOP_CTRL;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.idex_valid = valid_q;
    assign bus.idex_pc    = pc_q;
    assign bus.idex_rd1   = rd1_q;
    assign bus.idex_rd2   = rd2_q;
    assign bus.idex_imm   = imm_q;
    assign bus.idex_rs    = rs_q;
    assign bus.idex_rt    = rt_q;
    assign bus.idex_rd    = rd_q;
    assign bus.idex_ctrl  = ctrl_q;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic        stall_evt, flush_evt;

    // A front-end stall outside a memory freeze can only come from a load-use.
    assign stall_evt = !pc_write && !mem_busy;
    assign flush_evt = flush && !mem_busy;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall_evt);
        flush_cnt_d = flush_cnt_q + 32'(flush_evt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: two instances (LU_BUBBLES=1 and 3) share stimulus and are
// compared every cycle against a bubble-budget reference model.
module tb_idex_stage;
    import idex_stage_pkg::*;

    localparam int DW = 32;
    localparam int LU[2] = '{1, 3};
    localparam logic [11:0] LW_CTRL  = 12'hD80;
    localparam logic [11:0] ADD_CTRL = 12'h820;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [11:0] ctrl;
    } idex_t;

    logic clk = 1'b0;
    logic rst, flush, mem_busy;
    logic [1:0] pcw, ifw;
    logic [1:0][31:0] scnt, fcnt;

    logic          in_valid, in_use_rt;
    logic [31:0]   in_pc, in_rd1, in_rd2, in_imm;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [11:0]   in_ctrl;

    idex_t dut_o[2];
    idex_t m[2];
    int    rem[2];
    int unsigned m_stall[2], m_flush[2];
    int    obs_stall[2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    idex_stage_if #(.DW(DW)) bus0 ();
    idex_stage_if #(.DW(DW)) bus1 ();

    assign bus0.id_valid = in_valid;   assign bus1.id_valid = in_valid;
    assign bus0.id_pc = in_pc;         assign bus1.id_pc = in_pc;
    assign bus0.id_rd1 = in_rd1;       assign bus1.id_rd1 = in_rd1;
    assign bus0.id_rd2 = in_rd2;       assign bus1.id_rd2 = in_rd2;
    assign bus0.id_imm = in_imm;       assign bus1.id_imm = in_imm;
    assign bus0.id_rs = in_rs;         assign bus1.id_rs = in_rs;
    assign bus0.id_rt = in_rt;         assign bus1.id_rt = in_rt;
    assign bus0.id_rd = in_rd;         assign bus1.id_rd = in_rd;
    assign bus0.id_use_rt = in_use_rt; assign bus1.id_use_rt = in_use_rt;
    assign bus0.id_ctrl = in_ctrl;     assign bus1.id_ctrl = in_ctrl;

    idex_stage #(.LU_BUBBLES(1), .DW(DW)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .flush(flush), .mem_busy(mem_busy),
        .pc_write(pcw[0]), .ifid_write(ifw[0]), .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
    );

    idex_stage #(.LU_BUBBLES(3), .DW(DW)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .flush(flush), .mem_busy(mem_busy),
        .pc_write(pcw[1]), .ifid_write(ifw[1]), .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
    );

    always_comb begin
        dut_o[0].valid = bus0.idex_valid; dut_o[1].valid = bus1.idex_valid;
        dut_o[0].pc    = bus0.idex_pc;    dut_o[1].pc    = bus1.idex_pc;
        dut_o[0].rd1   = bus0.idex_rd1;   dut_o[1].rd1   = bus1.idex_rd1;
        dut_o[0].rd2   = bus0.idex_rd2;   dut_o[1].rd2   = bus1.idex_rd2;
        dut_o[0].imm   = bus0.idex_imm;   dut_o[1].imm   = bus1.idex_imm;
        dut_o[0].rs    = bus0.idex_rs;    dut_o[1].rs    = bus1.idex_rs;
        dut_o[0].rt    = bus0.idex_rt;    dut_o[1].rt    = bus1.idex_rt;
        dut_o[0].rd    = bus0.idex_rd;    dut_o[1].rd    = bus1.idex_rd;
        dut_o[0].ctrl  = bus0.idex_ctrl;  dut_o[1].ctrl  = bus1.idex_ctrl;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_haz(input int i);
        return m[i].valid && m[i].ctrl[MEMREAD_BIT] && (m[i].rt != 5'd0) && in_valid &&
               ((m[i].rt == in_rs) || (in_use_rt && (m[i].rt == in_rt)));
    endfunction

    // One clock: drive inputs, check combinational enables, clock, check registers.
    task automatic step(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rt, input logic [11:0] ctrl, input logic fl,
                        input logic mb);
        logic       stalls[2];
        logic       exp_en;
        idex_t      bub;
        rst = r; in_valid = v; in_rs = rs; in_rt = rt; in_use_rt = use_rt; in_ctrl = ctrl;
        flush = fl; mem_busy = mb;
        in_pc = $urandom; in_rd1 = $urandom; in_rd2 = $urandom; in_imm = $urandom;
        in_rd = 5'($urandom);
        bub = '{valid: 1'b0, pc: '0, rd1: '0, rd2: '0, imm: '0, rs: '0, rt: '0, rd: '0,
                ctrl: '0};
        #1;
        for (int i = 0; i < 2; i++) begin
            stalls[i] = !mb && !fl && (rem[i] > 0 || model_haz(i));
            if (!r) begin
                exp_en = !mb && !stalls[i];
                check($sformatf("pc_write[%0d]", i), 64'(pcw[i]), 64'(exp_en));
                check($sformatf("ifid_write[%0d]", i), 64'(ifw[i]), 64'(exp_en));
                if (!mb && !pcw[i]) obs_stall[i]++;
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m[i] = bub; rem[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else if (mb) begin
                // frozen
            end else if (fl) begin
                m[i] = bub; rem[i] = 0; m_flush[i]++;
            end else if (rem[i] > 0) begin
                m[i] = bub; rem[i]--; m_stall[i]++;
            end else if (stalls[i]) begin
                m[i] = bub; rem[i] = LU[i] - 1; m_stall[i]++;
            end else begin
                m[i] = '{valid: v, pc: in_pc, rd1: in_rd1, rd2: in_rd2, imm: in_imm, rs: rs,
                         rt: rt, rd: in_rd, ctrl: v ? ctrl : 12'h000};
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("idex_valid[%0d]", i), 64'(dut_o[i].valid), 64'(m[i].valid));
            check($sformatf("idex_ctrl[%0d]", i), 64'(dut_o[i].ctrl), 64'(m[i].ctrl));
            check($sformatf("idex_pc[%0d]", i), 64'(dut_o[i].pc), 64'(m[i].pc));
            check($sformatf("idex_rd12[%0d]", i), {dut_o[i].rd1, dut_o[i].rd2},
                  {m[i].rd1, m[i].rd2});
            check($sformatf("idex_imm[%0d]", i), 64'(dut_o[i].imm), 64'(m[i].imm));
            check($sformatf("idex_idx[%0d]", i), 64'({dut_o[i].rs, dut_o[i].rt, dut_o[i].rd}),
                  64'({m[i].rs, m[i].rt, m[i].rd}));
`ifdef IDEX_PERF_CNT_EN
            check($sformatf("stall_cnt[%0d]", i), 64'(scnt[i]), 64'(m_stall[i]));
            check($sformatf("flush_cnt[%0d]", i), 64'(fcnt[i]), 64'(m_flush[i]));
`else
            check($sformatf("stall_cnt[%0d]", i), 64'(scnt[i]), 64'd0);
            check($sformatf("flush_cnt[%0d]", i), 64'(fcnt[i]), 64'd0);
`endif
        end
    endtask

    // Bubble, load into IDEX, then ten cycles of a dependent add; count load-use stalls.
    task automatic run_seq(input string name, input logic [4:0] ld_rt, input logic [4:0] add_rs,
                           input logic [4:0] add_rt, input logic use_rt, input int flush_at,
                           input int busy_at, input int busy_len, input int exp0,
                           input int exp1);
        step(0, 0, 0, 0, 0, 12'h000, 0, 0);
        step(0, 1, 5'd1, ld_rt, 0, LW_CTRL, 0, 0);
        obs_stall[0] = 0;
        obs_stall[1] = 0;
        for (int k = 0; k < 10; k++)
            step(0, 1, add_rs, add_rt, use_rt, ADD_CTRL, k == flush_at,
                 (k >= busy_at) && (k < busy_at + busy_len));
        check({name, "_stalls[0]"}, 64'(obs_stall[0]), 64'(exp0));
        check({name, "_stalls[1]"}, 64'(obs_stall[1]), 64'(exp1));
    endtask

    initial begin
        rem = '{0, 0};
        m_stall = '{0, 0};
        m_flush = '{0, 0};
        obs_stall = '{0, 0};

        step(1, 1, 5'd3, 5'd4, 1, 12'hFFF, 0, 0);
        step(1, 1, 5'd3, 5'd4, 1, 12'hFFF, 0, 0);
        check("reset_valid", 64'(dut_o[1].valid), 64'd0);
        check("reset_ctrl", 64'(dut_o[1].ctrl), 64'd0);

        run_seq("rs_match", 5'd8, 5'd8, 5'd2, 0, -1, -1, 0, 1, 3);
        check("rs_captured", 64'(dut_o[0].rs), 64'd8);
        run_seq("rt_use", 5'd8, 5'd9, 5'd8, 1, -1, -1, 0, 1, 3);
        run_seq("rt_nouse", 5'd8, 5'd9, 5'd8, 0, -1, -1, 0, 0, 0);
        run_seq("load_r0", 5'd0, 5'd0, 5'd0, 1, -1, -1, 0, 0, 0);
        run_seq("flush_stall", 5'd8, 5'd8, 5'd2, 0, 1, -1, 0, 1, 1);
        run_seq("busy_stall", 5'd8, 5'd8, 5'd2, 0, -1, 1, 4, 1, 3);

        for (int n = 0; n < 400; n++) begin
            logic [11:0] c;
            c = 12'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), c,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
